// File: rtl/Purple_Jade_pkg.sv
// Shared Purple Jade package: common word size, memory-subsystem state encoding and defaults.
package Purple_Jade_pkg;

  localparam int WORD_SIZE_P = 16;
  localparam int PJ_MEM_CHANNELS_DEFAULT = 2;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } pj_mem_state_e;

endpackage

// File: rtl/bsg_mem_1r1w_sync.sv
// Synchronous 1R1W RAM with a registered read port; read data holds between reads.
// With read_write_same_addr_p set, a same-address read and write in one cycle returns the new data.
module bsg_mem_1r1w_sync #(
  parameter int width_p = 16,
  parameter int els_p = 1024,
  parameter int read_write_same_addr_p = 1,
  parameter int addr_width_lp = (els_p > 1) ? $clog2(els_p) : 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_r [els_p];

  always_ff @(posedge clk_i) begin
    if (!reset_i && w_v_i) begin
      mem_r[w_addr_i] <= w_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && r_v_i) begin
      if ((read_write_same_addr_p != 0) && w_v_i && (w_addr_i == r_addr_i)) begin
        r_data_o <= w_data_i;
      end else begin
        r_data_o <= mem_r[r_addr_i];
      end
    end
  end

endmodule

// File: rtl/pj_rr_arb.sv
// Round-robin arbiter: grants the first request at or after the pointer, wrapping;
// the pointer moves past the granted way only when the grant is accepted (yumi).
module pj_rr_arb #(
  parameter int WAYS_P = 2,
  parameter int ID_W = (WAYS_P > 1) ? $clog2(WAYS_P) : 1
) (
  input  logic              clk_i,
  input  logic              reset_ni,
  input  logic [WAYS_P-1:0] reqs_i,
  input  logic              yumi_i,
  output logic [WAYS_P-1:0] grants_o,
  output logic [ID_W-1:0]   grant_id_o
);

  logic [ID_W-1:0] rr_q;
  logic            found;
  int              idx;

  always_comb begin
    grants_o   = '0;
    grant_id_o = '0;
    found      = 1'b0;
    idx        = 0;
    for (int i = 0; i < WAYS_P; i++) begin
      idx = int'(rr_q) + i;
      if (idx >= WAYS_P) idx = idx - WAYS_P;
      if (!found && reqs_i[idx]) begin
        grants_o[idx] = 1'b1;
        grant_id_o    = ID_W'(idx);
        found         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rr_q <= '0;
    end else if (yumi_i) begin
      if (int'(grant_id_o) == WAYS_P - 1) rr_q <= '0;
      else rr_q <= grant_id_o + ID_W'(1);
    end
  end

endmodule

// File: rtl/pj_mem_arb.sv
// Multi-channel data memory: round-robin arbitration onto one single-port RAM, optional zero-fill.
// Define PJ_MEM_PARITY_EN to store a per-word even-parity bit and flag mismatches on read responses.
module pj_mem_arb
  import Purple_Jade_pkg::*;
#(
  parameter int WIDTH_P = WORD_SIZE_P,
  parameter int ADDR_WIDTH_P = 10,
  parameter int CHANNELS_P = PJ_MEM_CHANNELS_DEFAULT,
  parameter int INIT_ZERO_P = 1
) (
  input  logic                             clk_i,
  input  logic                             reset_ni,
  input  logic [CHANNELS_P-1:0]            req_v_i,
  input  logic [CHANNELS_P-1:0]            req_w_i,
  input  logic [CHANNELS_P*ADDR_WIDTH_P-1:0] req_addr_i,
  input  logic [CHANNELS_P*WIDTH_P-1:0]    req_data_i,
  output logic [CHANNELS_P-1:0]            req_ready_o,
  output logic [CHANNELS_P-1:0]            resp_v_o,
  output logic [WIDTH_P-1:0]               resp_data_o,
  output logic                             init_done_o
`ifdef PJ_MEM_PARITY_EN
  ,
  output logic                             parity_err_o
`endif
);

  localparam int CH_W = (CHANNELS_P > 1) ? $clog2(CHANNELS_P) : 1;
`ifdef PJ_MEM_PARITY_EN
  localparam int RAM_W = WIDTH_P + 1;
`else
  localparam int RAM_W = WIDTH_P;
`endif

  pj_mem_state_e           state_q;
  logic [ADDR_WIDTH_P-1:0] fill_addr_q;
  logic                    init_done_q;
  logic [CHANNELS_P-1:0]   resp_v_q;

  logic                    run;
  logic [CHANNELS_P-1:0]   grant;
  logic [CHANNELS_P-1:0]   accept_v;
  logic [CH_W-1:0]         grant_id;
  logic                    accept;
  logic                    is_write;
  logic [ADDR_WIDTH_P-1:0] sel_addr;
  logic [WIDTH_P-1:0]      sel_data;

  logic                    ram_w_v;
  logic [ADDR_WIDTH_P-1:0] ram_w_addr;
  logic [RAM_W-1:0]        ram_w_data;
  logic                    ram_r_v;
  logic [RAM_W-1:0]        ram_r_data;

  assign run = (state_q == RUN) && init_done_q;

  generate
    if (CHANNELS_P == 1) begin : g_single
      assign grant    = init_done_q;
      assign grant_id = '0;
    end else begin : g_multi
      pj_rr_arb #(.WAYS_P(CHANNELS_P)) u_arb (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .reqs_i     (req_v_i & {CHANNELS_P{run}}),
        .yumi_i     (accept),
        .grants_o   (grant),
        .grant_id_o (grant_id)
      );
    end
  endgenerate

  assign req_ready_o = grant;
  assign accept_v    = req_v_i & grant;
  assign accept      = |accept_v;
  assign is_write    = req_w_i[grant_id];
  assign sel_addr    = req_addr_i[int'(grant_id)*ADDR_WIDTH_P +: ADDR_WIDTH_P];
  assign sel_data    = req_data_i[int'(grant_id)*WIDTH_P +: WIDTH_P];

  // INIT sweeps every address once; the transition to RUN and init_done share the last-fill edge.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= (INIT_ZERO_P != 0) ? INIT : RUN;
      fill_addr_q <= '0;
      init_done_q <= 1'b0;
      resp_v_q    <= '0;
    end else begin
      case (state_q)
        INIT: begin
          fill_addr_q <= fill_addr_q + 1'b1;
          resp_v_q    <= '0;
          if (&fill_addr_q) begin
            state_q     <= RUN;
            init_done_q <= 1'b1;
          end
        end
        RUN: begin
          init_done_q <= 1'b1;
          resp_v_q    <= (accept && !is_write) ? accept_v : '0;
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign ram_w_v    = (state_q == INIT) || (accept && is_write);
  assign ram_w_addr = (state_q == INIT) ? fill_addr_q : sel_addr;
  assign ram_r_v    = accept && !is_write;
`ifdef PJ_MEM_PARITY_EN
  assign ram_w_data = (state_q == INIT) ? '0 : {^sel_data, sel_data};
`else
  assign ram_w_data = (state_q == INIT) ? '0 : sel_data;
`endif

  bsg_mem_1r1w_sync #(
    .width_p                (RAM_W),
    .els_p                  (2 ** ADDR_WIDTH_P),
    .read_write_same_addr_p (1),
    .addr_width_lp          (ADDR_WIDTH_P)
  ) u_ram (
    .clk_i    (clk_i),
    .reset_i  (~reset_ni),
    .w_v_i    (ram_w_v),
    .w_addr_i (ram_w_addr),
    .w_data_i (ram_w_data),
    .r_v_i    (ram_r_v),
    .r_addr_i (sel_addr),
    .r_data_o (ram_r_data)
  );

  assign resp_v_o    = resp_v_q;
  assign init_done_o = init_done_q;
  assign resp_data_o = ram_r_data[WIDTH_P-1:0];
`ifdef PJ_MEM_PARITY_EN
  assign parity_err_o = (|resp_v_q) && (^ram_r_data);
`endif

endmodule

// File: tb/tb_pj_mem_arb.sv
// Directed bench for pj_mem_arb (3 channels, 16-word RAM, zero-fill on).
// Parity checks are compiled in only when PJ_MEM_PARITY_EN is defined.
module tb_pj_mem_arb;

  localparam int W  = 16;
  localparam int AW = 4;
  localparam int CH = 3;

  logic            clk;
  logic            reset_n;
  logic [CH-1:0]   req_v;
  logic [CH-1:0]   req_w;
  logic [CH*AW-1:0] req_addr;
  logic [CH*W-1:0] req_data;
  logic [CH-1:0]   req_ready;
  logic [CH-1:0]   resp_v;
  logic [W-1:0]    resp_data;
  logic            init_done;
`ifdef PJ_MEM_PARITY_EN
  logic            parity_err;
`endif

  int checks = 0;
  int errors = 0;

  pj_mem_arb #(
    .WIDTH_P(W), .ADDR_WIDTH_P(AW), .CHANNELS_P(CH), .INIT_ZERO_P(1)
  ) dut (
    .clk_i       (clk),
    .reset_ni    (reset_n),
    .req_v_i     (req_v),
    .req_w_i     (req_w),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_ready_o (req_ready),
    .resp_v_o    (resp_v),
    .resp_data_o (resp_data),
    .init_done_o (init_done)
`ifdef PJ_MEM_PARITY_EN
    ,
    .parity_err_o(parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int c, input bit v, input bit w,
                               input logic [AW-1:0] a, input logic [W-1:0] d);
    req_v[c] = v;
    req_w[c] = w;
    req_addr[c*AW +: AW] = a;
    req_data[c*W +: W] = d;
  endtask

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitInitDone(input string tag);
    int n;
    n = 0;
    while (!init_done && n < 100) begin
      stepCycle();
      n++;
    end
    checkOutput(tag, n, 16);
  endtask

  initial begin
    logic [CH-1:0] exp_g [4];
    logic [W-1:0]  exp_d [4];

    reset_n  = 1'b0;
    req_v    = '0;
    req_w    = '0;
    req_addr = '0;
    req_data = '0;
    #2;
    checkOutput("reset_init_done", init_done, 0);
    checkOutput("reset_ready", req_ready, 0);
    checkOutput("reset_resp_v", resp_v, 0);
    @(negedge clk);
    reset_n = 1'b1;
    waitInitDone("init_cycles");

    // first read after fill returns zero
    applyStimulus(0, 1, 0, 4'hA, 16'h0);
    #1;
    checkOutput("rd0_ready", req_ready, 3'b001);
    stepCycle();
    applyStimulus(0, 0, 0, 4'h0, 16'h0);
    checkOutput("rd0_resp_v", resp_v, 3'b001);
    checkOutput("rd0_data", resp_data, 16'h0000);

    // write then read-after-write on channel 0
    applyStimulus(0, 1, 1, 4'h3, 16'h1234);
    #1;
    checkOutput("wr_ready", req_ready, 3'b001);
    stepCycle();
    applyStimulus(0, 1, 0, 4'h3, 16'h0);
    checkOutput("wr_no_resp", resp_v, 3'b000);
    stepCycle();
    applyStimulus(0, 0, 0, 4'h0, 16'h0);
    checkOutput("raw_resp_v", resp_v, 3'b001);
    checkOutput("raw_data", resp_data, 16'h1234);
    stepCycle();
    checkOutput("idle_resp_v", resp_v, 3'b000);
    checkOutput("hold_data", resp_data, 16'h1234);
    checkOutput("idle_ready", req_ready, 3'b000);

    // channel 1 writes; rr ends at 2
    applyStimulus(1, 1, 1, 4'h1, 16'h1111);
    stepCycle();
    applyStimulus(1, 1, 1, 4'h2, 16'h2222);
    stepCycle();

    // ch0 and ch1 contend: grants alternate, responses one cycle behind
    applyStimulus(0, 1, 0, 4'h1, 16'h0);
    applyStimulus(1, 1, 0, 4'h2, 16'h0);
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b001; exp_g[3] = 3'b010;
    exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h1111; exp_d[3] = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput($sformatf("alt_grant%0d", k), req_ready, exp_g[k]);
      if (k > 0) begin
        checkOutput($sformatf("alt_resp_v%0d", k), resp_v, exp_g[k-1]);
        checkOutput($sformatf("alt_data%0d", k), resp_data, exp_d[k-1]);
      end
      stepCycle();
    end
    applyStimulus(0, 0, 0, 4'h0, 16'h0);
    applyStimulus(1, 0, 0, 4'h0, 16'h0);
    checkOutput("alt_resp_v4", resp_v, 3'b010);
    checkOutput("alt_data4", resp_data, 16'h2222);

    // channel 2 alone is granted every cycle
    applyStimulus(2, 1, 0, 4'h1, 16'h0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("ch2_grant%0d", k), req_ready, 3'b100);
      stepCycle();
      checkOutput($sformatf("ch2_resp%0d", k), resp_v, 3'b100);
    end
    checkOutput("ch2_data", resp_data, 16'h1111);

    // all three contend from rr=0: 001, 010, 100
    applyStimulus(0, 1, 0, 4'h1, 16'h0);
    applyStimulus(1, 1, 0, 4'h2, 16'h0);
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100;
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("rr3_grant%0d", k), req_ready, exp_g[k]);
      stepCycle();
    end
    applyStimulus(0, 0, 0, 4'h0, 16'h0);
    applyStimulus(1, 0, 0, 4'h0, 16'h0);
    applyStimulus(2, 0, 0, 4'h0, 16'h0);
    checkOutput("rr3_resp_v", resp_v, 3'b100);
    checkOutput("rr3_data", resp_data, 16'h1111);

`ifdef PJ_MEM_PARITY_EN
    applyStimulus(0, 1, 1, 4'h5, 16'h0003);
    stepCycle();
    applyStimulus(0, 0, 0, 4'h0, 16'h0);
    stepCycle();
    dut.u_ram.mem_r[5] = dut.u_ram.mem_r[5] ^ 17'h00001;
    applyStimulus(0, 1, 0, 4'h5, 16'h0);
    stepCycle();
    applyStimulus(0, 0, 0, 4'h0, 16'h0);
    checkOutput("par_err", parity_err, 1);
    checkOutput("par_data", resp_data, 16'h0002);
    stepCycle();
    checkOutput("par_err_pulse", parity_err, 0);
`endif

    // reset mid-fill at counter 7
    reset_n = 1'b0;
    #1;
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(0, 1, 0, 4'h3, 16'h0);
    for (int k = 0; k < 7; k++) stepCycle();
    checkOutput("init_ready_low", req_ready, 3'b000);
    checkOutput("init_done_low", init_done, 0);
    reset_n = 1'b0;
    #1;
    checkOutput("midreset_done", init_done, 0);
    checkOutput("midreset_ready", req_ready, 0);
    checkOutput("midreset_resp", resp_v, 0);
    @(negedge clk);
    reset_n = 1'b1;
    waitInitDone("refill_cycles");
    #1;
    checkOutput("refill_ready", req_ready, 3'b001);
    stepCycle();
    applyStimulus(0, 0, 0, 4'h0, 16'h0);
    checkOutput("refill_resp_v", resp_v, 3'b001);
    checkOutput("refill_data", resp_data, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pj_mem_arb.md
Name: pj_mem_arb

Overview:
- Parametrised data-memory subsystem for the next core generation. Replaces the single-port, fixed-size data memory.
- Arbitrates CHANNELS_P requesters (core load/store, loader/DMA, debug) onto one synchronous single-port RAM. Uses round-robin grant, valid/ready request handshake and fixed-latency responses.
- Optionally zero-fills the RAM after reset.
- Optionally stores and checks a parity bit per word.

Parameters:
- WIDTH_P, 16, data word width in bits.
- ADDR_WIDTH_P, 10, address width; depth = 2**ADDR_WIDTH_P words.
- CHANNELS_P, 2, number of requester channels (≥1); channel 0 is the core.
- INIT_ZERO_P, 1, 1 = zero-fill the whole RAM after reset before accepting requests; 0 = skip.

Ports:
- clk_i  in  1  sole clock, rising edge.
- reset_ni  in  1  asynchronous, active-low reset.
- req_v_i  in  CHANNELS_P  per-channel request valid.
- req_w_i  in  CHANNELS_P  per-channel write (1) / read (0).
- req_addr_i  in  CHANNELS_P*ADDR_WIDTH_P  packed addresses; channel c occupies bits [c*ADDR_WIDTH_P +: ADDR_WIDTH_P].
- req_data_i  in  CHANNELS_P*WIDTH_P  packed write data.
- req_ready_o  out  CHANNELS_P  one-hot grant; a request is accepted when req_v_i[c] & req_ready_o[c].
- resp_v_o  out  CHANNELS_P  one-hot read-response valid.
- resp_data_o  out  WIDTH_P  read data, shared across channels and qualified by resp_v_o.
- init_done_o  out  1  high once the RAM is usable.
- parity_err_o  out  1  parity error flag; exists only with PJ_MEM_PARITY_EN.

Behaviour:
- Reset (reset_ni low, asynchronous):
  - rr pointer = 0; resp_v_o = 0; req_ready_o = 0; init_done_o = 0; parity_err_o = 0.
  - State = INIT when INIT_ZERO_P is 1, otherwise RUN.
  - RAM contents are not reset.
- State machine, states INIT and RUN:
  - INIT: an internal counter writes 0 to address 0..2**ADDR_WIDTH_P-1, one word per cycle. req_ready_o = 0.
  - After the last address is written, go to RUN; init_done_o rises that same edge. INIT takes exactly 2**ADDR_WIDTH_P cycles.
  - RUN: init_done_o = 1 and stays there until the next reset.
  - Reset asserted mid-INIT restarts the fill at address 0.
- Arbitration (RUN only; combinational from req_v_i and rr pointer):
  - Grant the first requesting channel at or after rr, wrapping modulo CHANNELS_P. At most one grant per cycle.
  - req_ready_o[c] is high only for the granted channel. No requester gets ready without valid.
  - On an accepted request, rr <= granted+1 mod CHANNELS_P. With no accept, rr holds.
- Write: the RAM is written at the accepting edge. No response is generated.
- Read:
  - resp_v_o[granted] = 1 exactly one cycle after the accepting edge, with resp_data_o = RAM[addr].
  - Responses have no backpressure; back-to-back reads give back-to-back responses.
  - When resp_v_o = 0, resp_data_o holds its last value.
- Read-after-write: a read accepted the cycle after a write to the same address returns the new data.
- Starvation bound: any channel holding valid is granted within CHANNELS_P accepted cycles.
- CHANNELS_P = 1: rr logic degenerates; req_ready_o = init_done_o.

Optional Feature:
- Macro: PJ_MEM_PARITY_EN.
- Defined:
  - RAM width is WIDTH_P+1; the stored bit is the even parity (XOR) of the data.
  - INIT writes parity 0.
  - On each read response, recompute parity. On mismatch, pulse parity_err_o for that same cycle; data is still returned unchanged.
- Undefined: RAM width is WIDTH_P; the parity_err_o port is absent.

Decomposition:
- Shared package Purple_Jade_pkg gets:
  - typedef pj_mem_state_e {INIT, RUN};
  - constant PJ_MEM_CHANNELS_DEFAULT = 2;
  - WIDTH_P default tied to the existing WORD_SIZE_P.
- One sub-module: pj_rr_arb, the round-robin arbiter (req vector, yumi/accept, grant one-hot, pointer state), reusable elsewhere.
- RAM is the existing bsg_mem_1r1w_sync with read_write_same_addr_p=1, driven from the single muxed port.

Test Plan:
- Reset, INIT_ZERO_P=1, ADDR_WIDTH_P=4 -> init_done_o rises after exactly 16 cycles; then a read of addr 0xA returns 0x0000.
- ch0 writes 0x1234 to addr 3, next cycle ch0 reads addr 3 -> resp_v_o=01 one cycle later, resp_data_o=0x1234.
- ch0 and ch1 hold valid reads of addr 1/2 for 4 cycles -> grants alternate 01,10,01,10; responses follow one cycle behind.
- CHANNELS_P=3, only ch2 requesting for 3 cycles -> granted every cycle; rr stays cycling back to ch2.
- Drop reset_ni mid-INIT at counter 7 -> all outputs 0 immediately; after release the fill restarts at 0 and init_done_o comes 16 cycles later.
- PJ_MEM_PARITY_EN: force a flip of stored bit 0 at addr 5, then read addr 5 -> parity_err_o high one cycle with the resp, data returned as stored.
